// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
// The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package control_pkg;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StBranch, StJump, StAddiEx, StAddiWb, StTrap
  } state_e;
`else
  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StBranch, StJump, StAddiEx, StAddiWb
  } state_e;
`endif

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct -> ALUControl decode for R-type instructions.
// Unknown funct codes fall back to add rather than trapping.
module alu_decoder
  import control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    unique case (funct)
      FnSub:   alu_control = AluSub;
      FnAnd:   alu_control = AluAnd;
      FnOr:    alu_control = AluOr;
      FnSlt:   alu_control = AluSlt;
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM with memory ready handshake.
// Define ILLEGAL_TRAP_EN to lock in a TRAP state on undefined opcodes.
module multicycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [2:0] funct_alu;
  logic       ir_write, pc_write;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (funct_alu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    IorD       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    ALUSrcA    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcB    = SrcBReg;
    PCSrc      = PcSrcAlu;
    ALUControl = AluAnd;
    instr_done = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        MemRead    = 1'b1;
        ALUSrcB    = SrcBFour;
        ALUControl = AluAdd;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        ALUSrcB    = SrcBImmSh;
        ALUControl = AluAdd;
        unique case (opcode)
          OpLw, OpSw:   state_d = StMemAdr;
          OpRtype:      state_d = StExec;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          OpAddi:       state_d = StAddiEx;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = StTrap;
`else
            state_d    = StFetch;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SrcBImm;
        ALUControl = AluAdd;
        state_d    = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StExec: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUControl = AluSub;
        PCSrc      = PcSrcAluOut;
        pc_write   = (opcode == OpBne) ? ~zero : zero;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        PCSrc      = PcSrcJump;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SrcBImm;
        ALUControl = AluAdd;
        state_d    = StAddiWb;
      end
      StAddiWb: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
`ifdef ILLEGAL_TRAP_EN
      StTrap: begin
        illegal = 1'b1;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  // No PC/IR update may slip through while reset is held.
  assign IRWrite = ir_write & rst_n;
  assign PCWrite = pc_write & rst_n;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control; honours ILLEGAL_TRAP_EN.
module tb_multicycle_control;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       IorD, IRWrite, PCWrite, ALUSrcA, RegDst, MemToReg, RegWrite, MemRead, MemWrite;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .ALUSrcA    (ALUSrcA),
    .RegDst     (RegDst),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  logic [17:0] act;
  assign act = {IorD, IRWrite, PCWrite, ALUSrcA, RegDst, MemToReg, RegWrite, MemRead,
                MemWrite, ALUSrcB, PCSrc, ALUControl, instr_done, illegal};

  typedef enum int {
    PhReset, PhFetch, PhDecode, PhMemAdr, PhMemRd, PhMemWb, PhMemWr, PhExec, PhAluWb,
    PhBranch, PhJump, PhAddiEx, PhAddiWb, PhTrap
  } ph_e;

  typedef struct {
    logic [17:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000;

  function automatic bit known_op(logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, BNE, JMP, ADDI};
  endfunction

  function automatic logic [2:0] alu_for(logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected strobes for one cycle of a given instruction phase.
  function automatic logic [17:0] model(ph_e ph, logic [5:0] op, logic [5:0] fn,
                                        logic z, logic mr);
    logic       iord = 0, irw = 0, pcw = 0, srca = 0, rdst = 0, m2r = 0, rw = 0;
    logic       mrd = 0, mwr = 0, done = 0, ill = 0;
    logic [1:0] srcb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b000;
    case (ph)
      PhReset:  begin mrd = 1; srcb = 2'b01; alu = 3'b010; end
      PhFetch:  begin mrd = 1; srcb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
      PhDecode: begin srcb = 2'b11; alu = 3'b010; done = !known_op(op) && !TrapEn; end
      PhMemAdr: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      PhMemRd:  begin iord = 1; mrd = 1; end
      PhMemWb:  begin m2r = 1; rw = 1; done = 1; end
      PhMemWr:  begin iord = 1; mwr = 1; done = mr; end
      PhExec:   begin srca = 1; alu = alu_for(fn); end
      PhAluWb:  begin rdst = 1; rw = 1; done = 1; end
      PhBranch: begin
        srca = 1; alu = 3'b110; pcs = 2'b01; done = 1;
        pcw = (op == BEQ) ? z : !z;
      end
      PhJump:   begin pcs = 2'b10; pcw = 1; done = 1; end
      PhAddiEx: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      PhAddiWb: begin rw = 1; done = 1; end
      PhTrap:   begin ill = 1; end
      default:  ;
    endcase
    return {iord, irw, pcw, srca, rdst, m2r, rw, mrd, mwr, srcb, pcs, alu, done, ill};
  endfunction

  // Monitor: one expected word per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  // Drive one cycle (called at posedge+1), queue its expectation, advance.
  task automatic step(ph_e ph, logic mr, int zs, string nm);
    mem_ready = mr;
    zero      = (zs < 0) ? 1'($urandom) : 1'(zs);
    sb.push_back('{v: model(ph, opcode, funct, zero, mr), name: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq(string nm);
    rst_n = 1'b0;
    step(PhReset, 1'b1, -1, {nm, ".rst"});
    rst_n = 1'b1;
    step(PhFetch, 1'b0, -1, {nm, ".rst_exit"});
  endtask

  task automatic fetch_decode(logic [5:0] op, logic [5:0] fn, int fw, string nm);
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    repeat (fw) step(PhFetch, 1'b0, -1, {nm, ".fetch_wait"});
    step(PhFetch, 1'b1, -1, {nm, ".fetch"});
    opcode = op;
    funct  = fn;
    step(PhDecode, 1'($urandom), -1, {nm, ".decode"});
  endtask

  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw, int zs, string nm);
    if (fw < 0) fw = $urandom_range(0, 2);
    if (mw < 0) mw = $urandom_range(0, 2);
    fetch_decode(op, fn, fw, nm);
    case (op)
      LW: begin
        step(PhMemAdr, 1'($urandom), -1, {nm, ".memadr"});
        repeat (mw) step(PhMemRd, 1'b0, -1, {nm, ".memrd_wait"});
        step(PhMemRd, 1'b1, -1, {nm, ".memrd"});
        step(PhMemWb, 1'($urandom), -1, {nm, ".memwb"});
      end
      SW: begin
        step(PhMemAdr, 1'($urandom), -1, {nm, ".memadr"});
        repeat (mw) step(PhMemWr, 1'b0, -1, {nm, ".memwr_wait"});
        step(PhMemWr, 1'b1, -1, {nm, ".memwr"});
      end
      RT: begin
        step(PhExec, 1'($urandom), -1, {nm, ".exec"});
        step(PhAluWb, 1'($urandom), -1, {nm, ".aluwb"});
      end
      BEQ, BNE: step(PhBranch, 1'($urandom), zs, {nm, ".branch"});
      JMP: step(PhJump, 1'($urandom), -1, {nm, ".jump"});
      ADDI: begin
        step(PhAddiEx, 1'($urandom), -1, {nm, ".addiex"});
        step(PhAddiWb, 1'($urandom), -1, {nm, ".addiwb"});
      end
      default: begin
        if (TrapEn) begin
          repeat (4) step(PhTrap, 1'($urandom), -1, {nm, ".trap"});
          reset_seq(nm);
        end
      end
    endcase
  endtask

  initial begin
    logic [5:0] op, fn;
    logic [5:0] fns[5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    @(posedge clk);
    #1;
    step(PhReset, 1'b0, -1, "reset.idle");
    step(PhReset, 1'b1, -1, "reset.ready_masked");
    rst_n = 1'b1;

    run_instr(LW, 6'h00, 0, 0, -1, "lw_min");
    run_instr(SW, 6'h00, 0, 3, -1, "sw_wait3");
    run_instr(BEQ, 6'h00, 0, 0, 1, "beq_taken");
    run_instr(BNE, 6'h00, 0, 0, 1, "bne_not_taken");
    run_instr(BNE, 6'h00, 1, 0, 0, "bne_taken");
    run_instr(RT, 6'h2a, 0, 0, -1, "rtype_slt");
    run_instr(RT, 6'h3f, 0, 0, -1, "rtype_unknown_funct");
    run_instr(ADDI, 6'h00, 2, 0, -1, "addi");
    run_instr(JMP, 6'h00, 0, 0, -1, "jump");
    run_instr(6'b111111, 6'h00, 0, 0, -1, "illegal_3f");

    // Reset abandons an lw stalled in MEMRD; the next lw must run cleanly.
    fetch_decode(LW, 6'h00, 0, "lw_abort");
    step(PhMemAdr, 1'b1, -1, "lw_abort.memadr");
    step(PhMemRd, 1'b0, -1, "lw_abort.memrd_wait");
    reset_seq("lw_abort");
    run_instr(LW, 6'h00, 1, 1, -1, "lw_after_abort");

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 8))
        0: op = LW;
        1: op = SW;
        2, 7: op = RT;
        3: op = BEQ;
        4: op = BNE;
        5: op = JMP;
        6: op = ADDI;
        default: begin
          op = 6'($urandom);
          while (known_op(op)) op = 6'($urandom);
        end
      endcase
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, -1, -1, -1, $sformatf("rand%0d", i));
    end

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control sequencer for the MIPS-subset core. Decodes opcode/funct from the instruction register, steps the shared datapath (single ALU, single memory port, register file, PC) through one instruction over 3–5+ cycles, and stalls on a memory ready handshake. Replaces single-cycle control when the core is built with one unified memory and one ALU.

## Interface
Parameters:
- none; all encodings live in the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle
- IorD, IRWrite, PCWrite, ALUSrcA, RegDst, MemToReg, RegWrite, MemRead, MemWrite  out  1  datapath strobes/selects
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  see Configuration

## Operation
- Moore FSM; all outputs combinational from state, except IRWrite/PCWrite/PC branch gating which also use mem_ready/zero.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite=PCWrite=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next by opcode: 100011/101011→MEMADR, 000000→EXEC, 000100/000101→BRANCH, 000010→JUMP, 001000→ADDIEX, other→see Configuration.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw→MEMRD, sw→MEMWR.
- MEMRD: IorD=1, MemRead=1; hold until mem_ready→MEMWB. MEMWB: RegDst=0, MemToReg=1, RegWrite=1→FETCH.
- MEMWR: IorD=1, MemWrite=1; hold until mem_ready→FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct → add, no trap)→ALUWB. ALUWB: RegDst=1, RegWrite=1→FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01; PCWrite = zero for beq, ~zero for bne →FETCH.
- JUMP: PCSrc=10, PCWrite=1→FETCH. ADDIEX: ALUSrcA=1, ALUSrcB=10, add→ADDIWB: RegDst=0, MemToReg=0, RegWrite=1→FETCH.
- Unlisted outputs are 0 in every state.
- instr_done=1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWR when mem_ready.

## Timing
- Reset: state=FETCH immediately on rst_n low; with mem_ready=0 outputs are MemRead=1, ALUSrcB=01, ALUControl=010, all else 0. IRWrite/PCWrite forced 0 while rst_n low regardless of mem_ready.
- Reset mid-instruction abandons it; no writes complete after rst_n falls.
- Minimum latency (mem_ready always 1): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles; each FETCH/MEMRD/MEMWR wait cycle adds one.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

## Configuration
- ILLEGAL_TRAP_EN defined: undefined opcode in DECODE→TRAP; TRAP holds forever (only reset exits), illegal=1, all strobes 0, instr_done=0.
- Undefined: undefined opcode→FETCH as a 2-cycle NOP with instr_done pulsed in DECODE; illegal tied 0; no TRAP state.

## Structure
- control_pkg: state enum, opcode/funct constants, ALUControl codes, ALUSrcB/PCSrc encodings.
- Sub-module alu_decoder: combinational funct→ALUControl, used in EXEC.

## Test plan
- lw, mem_ready=1: FETCH→DECODE→MEMADR→MEMRD→MEMWB, MemToReg=RegWrite=1 in cycle 5, instr_done there.
- sw with mem_ready low 3 cycles in MEMWR: MemWrite held 4 cycles, no RegWrite, back to FETCH.
- beq zero=1 → PCWrite=1, PCSrc=01 in cycle 3; bne zero=1 → PCWrite=0.
- R-type funct 101010 → ALUControl=111 in EXEC, RegDst=1 RegWrite=1 in ALUWB.
- opcode 111111: with ILLEGAL_TRAP_EN illegal=1 held until rst_n; without it back in FETCH in cycle 3.
- rst_n pulsed low during MEMRD: state FETCH, IRWrite/PCWrite/RegWrite 0; next lw completes normally.
